// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronises a raw push-button pin, debounces it with a hold-stable
// counter and emits registered PRESS / RELEASE / LONG_PRESS pulses plus the clean level.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int CNT_W           = 26
) (
  input  logic cclk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_press_o
);

  localparam logic [1:0] IDLE_LOW  = 2'd0;
  localparam logic [1:0] WAIT_HIGH = 2'd1;
  localparam logic [1:0] IDLE_HIGH = 2'd2;
  localparam logic [1:0] WAIT_LOW  = 2'd3;

  localparam logic [CNT_W-1:0] DCNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] dcnt_q, dcnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  always_ff @(posedge cclk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // Any sample that agrees with the current level drops back to the idle state,
  // so dcnt only ever counts an unbroken run of disagreeing samples.
  always_comb begin
    state_d   = state_q;
    dcnt_d    = dcnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      IDLE_LOW: begin
        if (sync2_q) begin
          state_d = WAIT_HIGH;
          dcnt_d  = '0;
        end
      end
      WAIT_HIGH: begin
        if (!sync2_q) begin
          state_d = IDLE_LOW;
        end else if (dcnt_q == DCNT_MAX) begin
          state_d = IDLE_HIGH;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          dcnt_d = dcnt_q + CNT_W'(1);
        end
      end
      IDLE_HIGH: begin
        if (!sync2_q) begin
          state_d = WAIT_LOW;
          dcnt_d  = '0;
        end
      end
      WAIT_LOW: begin
        if (sync2_q) begin
          state_d = IDLE_HIGH;
        end else if (dcnt_q == DCNT_MAX) begin
          state_d   = IDLE_LOW;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          dcnt_d = dcnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE_LOW;
    endcase
  end

  always_ff @(posedge cclk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE_LOW;
      dcnt_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dcnt_q    <= dcnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

  generate
    if (HOLD_CYCLES == 0) begin : g_no_hold
      assign long_press_o = 1'b0;
    end else begin : g_hold
      localparam logic [CNT_W-1:0] HCNT_MAX = CNT_W'(HOLD_CYCLES - 1);

      logic [CNT_W-1:0] hcnt_q, hcnt_d;
      logic             fired_q, fired_d;
      logic             long_q, long_d;

      // A release on the threshold edge wins, keeping one pulse per cycle.
      always_comb begin
        hcnt_d  = hcnt_q;
        fired_d = fired_q;
        long_d  = 1'b0;
        if (press_d) begin
          hcnt_d  = '0;
          fired_d = 1'b0;
        end else if (level_q) begin
          if (hcnt_q != HCNT_MAX) begin
            hcnt_d = hcnt_q + CNT_W'(1);
          end
          if (hcnt_d == HCNT_MAX && !fired_q && !release_d) begin
            long_d  = 1'b1;
            fired_d = 1'b1;
          end
        end
      end

      always_ff @(posedge cclk_i or posedge rst_i) begin
        if (rst_i) begin
          hcnt_q  <= '0;
          fired_q <= 1'b0;
          long_q  <= 1'b0;
        end else begin
          hcnt_q  <= hcnt_d;
          fired_q <= fired_d;
          long_q  <= long_d;
        end
      end

      assign long_press_o = long_q;
    end
  endgenerate

endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: directed scenarios plus a random bounce soak, each checked against
// a cycle-level reference model of the debounced button behaviour.
module tb_btn_conditioner;
  localparam int DB   = 4;
  localparam int HOLD = 10;
  localparam int CW   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn = 1'b0;
  logic level, press, rel, lng;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .HOLD_CYCLES    (HOLD),
    .CNT_W          (CW)
  ) dut (
    .cclk_i      (clk),
    .rst_i       (rst),
    .btn_i       (btn),
    .level_o     (level),
    .press_o     (press),
    .release_o   (rel),
    .long_press_o(lng)
  );

  // Reference model: the pin reaches the decision logic two edges late; the level
  // toggles once DB+1 consecutive samples disagree with it; LONG_PRESS comes HOLD-1
  // edges after PRESS unless the button was released by then.
  logic p1 = 1'b0, p2 = 1'b0;
  int   run = 0, since = 0;
  bit   armed = 1'b0;
  logic m_level = 1'b0, m_press = 1'b0, m_rel = 1'b0, m_long = 1'b0;

  always @(posedge clk or posedge rst) begin : model
    logic s;
    if (rst) begin
      p1 = 1'b0; p2 = 1'b0; run = 0; since = 0; armed = 1'b0;
      m_level = 1'b0; m_press = 1'b0; m_rel = 1'b0; m_long = 1'b0;
    end else begin
      s  = p2;
      p2 = p1;
      p1 = btn;
      m_press = 1'b0; m_rel = 1'b0; m_long = 1'b0;
      run = (s != m_level) ? run + 1 : 0;
      if (run == DB + 1) begin
        run     = 0;
        m_level = s;
        if (s) begin
          m_press = 1'b1; since = 0; armed = (HOLD != 0);
        end else begin
          m_rel = 1'b1; armed = 1'b0;
        end
      end else if (m_level && armed) begin
        since++;
        if (since == HOLD - 1) begin
          m_long = 1'b1; armed = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({level, press, rel, lng} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_state: got L=%b P=%b R=%b LP=%b, required all 0", level, press, rel, lng);
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({level, press, rel, lng} !== {m_level, m_press, m_rel, m_long}) begin
        fails++;
        $display("FAIL reset_idle cyc %0d: got %b%b%b%b required %b%b%b%b", i,
                 level, press, rel, lng, m_level, m_press, m_rel, m_long);
      end
    end
    $display("test_reset: done");
  endtask

  task automatic test_bounce_reject();
    for (int i = 1; i <= 18; i++) begin
      btn = (i <= 3);
      tick();
      checks++;
      if ({level, press, rel, lng} !== 4'b0000) begin
        fails++;
        $display("FAIL bounce_reject cyc %0d: got L=%b P=%b R=%b LP=%b, required all 0", i, level, press, rel, lng);
      end
    end
    $display("test_bounce_reject: done");
  endtask

  // Hold lengths 30, 8 and 10 samples: PRESS on edge 7, RELEASE on edge hold+7,
  // LONG_PRESS on edge 16 only if the level is still high there.
  task automatic test_press_hold();
    int   holds[3] = '{30, 8, 10};
    logic el, ep, er, elp;
    foreach (holds[h]) begin
      btn = 1'b1;
      for (int i = 1; i <= holds[h] + 20; i++) begin
        tick();
        if (i == holds[h]) btn = 1'b0;
        el  = (i >= 7 && i < holds[h] + 7);
        ep  = (i == 7);
        er  = (i == holds[h] + 7);
        elp = (holds[h] + 7 > 16 && i == 16);
        checks++;
        if ({level, press, rel, lng} !== {el, ep, er, elp}) begin
          fails++;
          $display("FAIL press_hold%0d cyc %0d: got L=%b P=%b R=%b LP=%b, required L=%b P=%b R=%b LP=%b",
                   holds[h], i, level, press, rel, lng, el, ep, er, elp);
        end
        checks++;
        if ({level, press, rel, lng} !== {m_level, m_press, m_rel, m_long}) begin
          fails++;
          $display("FAIL press_hold_model cyc %0d: got %b%b%b%b required %b%b%b%b", i,
                   level, press, rel, lng, m_level, m_press, m_rel, m_long);
        end
      end
      $display("test_press_hold: hold of %0d cycles done", holds[h]);
    end
  endtask

  task automatic test_release_bounce();
    btn = 1'b1;
    repeat (10) tick();
    for (int j = 1; j <= 16; j++) begin
      btn = (j == 3);
      tick();
      checks++;
      if ({level, press, rel, lng} !== {(j < 10), 1'b0, (j == 10), (j == 6)}) begin
        fails++;
        $display("FAIL release_bounce cyc %0d: got L=%b P=%b R=%b LP=%b, required L=%b P=0 R=%b LP=%b",
                 j, level, press, rel, lng, (j < 10), (j == 10), (j == 6));
      end
    end
    $display("test_release_bounce: done");
  endtask

  task automatic test_reset_mid();
    btn = 1'b1;
    repeat (4) tick();
    for (int pass = 0; pass < 2; pass++) begin
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({level, press, rel, lng} !== 4'b0000) begin
        fails++;
        $display("FAIL reset_async%0d: got L=%b P=%b R=%b LP=%b, required all 0", pass, level, press, rel, lng);
      end
      tick();
      tick();
      rst = 1'b0;
      // First edge after RST falls is the release edge; PRESS follows DB+2 edges later.
      for (int i = 1; i <= (pass == 0 ? 12 : 20); i++) begin
        tick();
        checks++;
        if ({level, press, rel, lng} !== {(i >= 7), (i == 7), 1'b0, (i == 16)}) begin
          fails++;
          $display("FAIL reset_repress%0d cyc %0d: got L=%b P=%b R=%b LP=%b, required L=%b P=%b R=0 LP=%b",
                   pass, i, level, press, rel, lng, (i >= 7), (i == 7), (i == 16));
        end
      end
    end
    btn = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      checks++;
      if ({level, press, rel, lng} !== {m_level, m_press, m_rel, m_long}) begin
        fails++;
        $display("FAIL reset_settle cyc %0d: got %b%b%b%b required %b%b%b%b", i,
                 level, press, rel, lng, m_level, m_press, m_rel, m_long);
      end
    end
    $display("test_reset_mid: done");
  endtask

  task automatic test_soak();
    int   cyc = 0, nb, ns, npress = 0;
    logic tgt = 1'b0;
    logic pl, pp, pr, plg;
    bit   last_press = 1'b0;
    pl = level; pp = press; pr = rel; plg = lng;
    while (cyc < 10000) begin
      tgt = ~tgt;
      nb  = $urandom_range(0, 6);
      ns  = $urandom_range(1, 12);
      for (int k = 0; k < nb + ns; k++) begin
        btn = (k < nb) ? 1'($urandom_range(0, 1)) : tgt;
        tick();
        cyc++;
        checks++;
        if ({level, press, rel, lng} !== {m_level, m_press, m_rel, m_long}) begin
          fails++;
          $display("FAIL soak_model cyc %0d: got %b%b%b%b required %b%b%b%b", cyc,
                   level, press, rel, lng, m_level, m_press, m_rel, m_long);
        end
        checks++;
        if (int'(press) + int'(rel) + int'(lng) > 1) begin
          fails++;
          $display("FAIL soak_one_pulse cyc %0d: got P=%b R=%b LP=%b, required at most one", cyc, press, rel, lng);
        end
        checks++;
        if ((press && pp) || (rel && pr) || (lng && plg)) begin
          fails++;
          $display("FAIL soak_width cyc %0d: got pulse held 2 cycles, required 1", cyc);
        end
        checks++;
        if ((press && last_press) || (rel && !last_press)) begin
          fails++;
          $display("FAIL soak_alternate cyc %0d: got P=%b R=%b after last_press=%b, required alternation",
                   cyc, press, rel, last_press);
        end
        checks++;
        if ((level !== pl) !== (press || rel)) begin
          fails++;
          $display("FAIL soak_level_change cyc %0d: got L %b->%b with P=%b R=%b, required change only with pulse",
                   cyc, pl, level, press, rel);
        end
        if (press) begin last_press = 1'b1; npress++; end
        if (rel) last_press = 1'b0;
        pl = level; pp = press; pr = rel; plg = lng;
      end
    end
    $display("test_soak: %0d cycles, %0d presses", cyc, npress);
  endtask

  initial begin
    test_reset();
    test_bounce_reject();
    test_press_hold();
    test_release_bounce();
    btn = 1'b0;
    repeat (12) tick();
    test_reset_mid();
    test_soak();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
